lpc_io_target: RTL and testbench

LPC bus I/O-cycle target front end. Decodes host I/O read and write cycles on LAD[3:0]/LFRAME#, and matches the 16-bit I/O address against a 256-byte window. It drives the single-cycle Addr/Rd/Wr/DataWr strobes of the downstream LPC register bank and returns that bank's registered DataRd to the host in the SYNC/DATA phases. It sits between the board LPC pins (tri-state handled at top level) and the register bank inside ODS_MR.

---
 rtl/lpc_io_target_pkg.sv | 37 +++
 rtl/lpc_nibble_shift.sv | 58 +++++
 rtl/lpc_io_target.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_lpc_io_target.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/lpc_io_target_pkg.sv
// ---------------------------------------------------------------------------
// lpc_io_target_pkg
//   Shared definitions for the LPC I/O-cycle target front end:
//   FSM state encoding, LAD nibble codes (START, SYNC values, cycle types)
//   and the I/O window match helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package lpc_io_target_pkg;

  typedef enum logic [3:0] {
    IDLE,
    CYCTYPE,
    ADDR,
    WDATA,
    HTAR,
    WAIT,
    SYNC,
    RDATA,
    PTAR
  } lpcState_e;

  localparam logic [3:0] START           = 4'h0;
  localparam logic [3:0] SYNC_READY      = 4'h0;
  localparam logic [3:0] SYNC_SHORT_WAIT = 4'h5;
  localparam logic [3:0] LAD_IDLE        = 4'hF;

  // Only LAD[3:1] carries the I/O cycle type; LAD[0] is reserved.
  localparam logic [2:0] CYCTYPE_IO_RD = 3'b000;
  localparam logic [2:0] CYCTYPE_IO_WR = 3'b001;

  // The window is 256 bytes, so only the upper address byte is compared.
  function automatic logic windowHit(input logic [7:0] addrHi,
                                     input logic [7:0] baseHi);
    return addrHi == baseHi;
  endfunction

endpackage

// File: rtl/lpc_nibble_shift.sv
// ---------------------------------------------------------------------------
// lpc_nibble_shift
//   Assembles a WIDTH-bit word from consecutive 4-bit LAD nibbles.
//   MSB_FIRST=1 places the first nibble at the top (LPC address order),
//   MSB_FIRST=0 places the first nibble at the bottom (LPC data order).
//
// Ports
//   LpcClock   in   LPC clock, rising edge
//   PciReset   in   synchronous active-high reset
//   clear      in   restart assembly (value and nibble count to zero)
//   shift      in   accept 'nibble' this clock
//   nibble     in   4-bit input nibble
//   nextValue  out  word including the current nibble (valid while shifting)
//   last       out  current nibble is the final one of the word
// ---------------------------------------------------------------------------
module lpc_nibble_shift
  import lpc_io_target_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             LpcClock,
  input  logic             PciReset,
  input  logic             clear,
  input  logic             shift,
  input  logic [3:0]       nibble,
  output logic [WIDTH-1:0] nextValue,
  output logic             last
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int CW      = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  logic [WIDTH-1:0] value;
  logic [CW-1:0]    count;

  // The assembled word is offered combinationally so the caller can act on
  // the complete value in the same clock the final nibble arrives.
  always_comb begin
    if (MSB_FIRST) begin
      nextValue = {value[WIDTH-5:0], nibble};
    end else begin
      nextValue = {nibble, value[WIDTH-1:4]};
    end
    last = (count == CW'(NIBBLES - 1));
  end

  always_ff @(posedge LpcClock) begin
    if (PciReset || clear) begin
      value <= '0;
      count <= '0;
    end else if (shift) begin
      value <= nextValue;
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/lpc_io_target.sv
// ---------------------------------------------------------------------------
// lpc_io_target
//   LPC bus I/O-cycle target front end. Decodes host I/O read/write cycles,
//   matches the 16-bit I/O address against a 256-byte window at BASE_ADDR,
//   issues single-clock Rd/Wr strobes to the register bank and returns the
//   bank's read data in the SYNC/DATA phases.
//
//   Optional feature: define LPC_SHORT_WAIT_EN to insert one short-wait
//   SYNC clock (LAD=4'h5) between the turnaround and the ready SYNC.
//
// Ports
//   LpcClock  in   33 MHz LPC clock, rising edge
//   PciReset  in   synchronous active-high reset
//   LFRAME_n  in   LPC frame, active-low
//   LadIn     in   LAD[3:0] sampled from pins
//   LadOut    out  LAD drive value (4'hF when idle)
//   LadOe     out  LAD output enable
//   Addr      out  register address, held until the next decoded cycle
//   Rd        out  one-clock read strobe
//   Wr        out  one-clock write strobe
//   DataWr    out  write data, held until the next write
//   DataRd    in   register bank read data, valid one clock after Rd
// ---------------------------------------------------------------------------
module lpc_io_target
  import lpc_io_target_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = 16'h0800
) (
  input  logic       LpcClock,
  input  logic       PciReset,
  input  logic       LFRAME_n,
  input  logic [3:0] LadIn,
  output logic [3:0] LadOut,
  output logic       LadOe,
  output logic [7:0] Addr,
  output logic       Rd,
  output logic       Wr,
  output logic [7:0] DataWr,
  input  logic [7:0] DataRd
);

  lpcState_e state, stateNext;
  logic      phase, phaseNext;

  logic        cycWrite;
  logic [7:0]  rdLatch;

  logic        startSeen;
  logic        frameOther;

  logic        shiftClear;
  logic        addrShift;
  logic        dataShift;
  logic [15:0] addrNext;
  logic        addrLast;
  logic [7:0]  dataNext;
  logic        dataLast;

  logic        cycTypeLoad;
  logic        cycTypeWrite;
  logic        setRd;
  logic        loadAddr;
  logic        loadDataWr;
  logic        latchRd;

  assign startSeen  = !LFRAME_n && (LadIn == START);
  assign frameOther = !LFRAME_n && (LadIn != START);

  lpc_nibble_shift #(
    .WIDTH    (16),
    .MSB_FIRST(1'b1)
  ) addrShifter (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .clear    (shiftClear),
    .shift    (addrShift),
    .nibble   (LadIn),
    .nextValue(addrNext),
    .last     (addrLast)
  );

  lpc_nibble_shift #(
    .WIDTH    (8),
    .MSB_FIRST(1'b0)
  ) dataShifter (
    .LpcClock (LpcClock),
    .PciReset (PciReset),
    .clear    (shiftClear),
    .shift    (dataShift),
    .nibble   (LadIn),
    .nextValue(dataNext),
    .last     (dataLast)
  );

  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      state <= IDLE;
      phase <= 1'b0;
    end else begin
      state <= stateNext;
      phase <= phaseNext;
    end
  end

  // A START nibble wins over every state, so a cycle that is cut short
  // never reaches the point where its strobe would have been issued.
  always_comb begin
    stateNext    = state;
    phaseNext    = phase;
    shiftClear   = 1'b0;
    addrShift    = 1'b0;
    dataShift    = 1'b0;
    cycTypeLoad  = 1'b0;
    cycTypeWrite = 1'b0;
    setRd        = 1'b0;
    loadAddr     = 1'b0;
    loadDataWr   = 1'b0;
    latchRd      = 1'b0;

    if (startSeen) begin
      stateNext  = CYCTYPE;
      phaseNext  = 1'b0;
      shiftClear = 1'b1;
    end else if (frameOther) begin
      stateNext = IDLE;
      phaseNext = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          stateNext = IDLE;
        end

        CYCTYPE: begin
          if (LadIn[3:1] == CYCTYPE_IO_RD) begin
            stateNext    = ADDR;
            cycTypeLoad  = 1'b1;
            cycTypeWrite = 1'b0;
          end else if (LadIn[3:1] == CYCTYPE_IO_WR) begin
            stateNext    = ADDR;
            cycTypeLoad  = 1'b1;
            cycTypeWrite = 1'b1;
          end else begin
            stateNext = IDLE;
          end
        end

        ADDR: begin
          addrShift = 1'b1;
          if (addrLast) begin
            if (windowHit(addrNext[15:8], BASE_ADDR[15:8])) begin
              loadAddr  = 1'b1;
              setRd     = !cycWrite;
              stateNext = cycWrite ? WDATA : HTAR;
              phaseNext = 1'b0;
            end else begin
              stateNext = IDLE;
            end
          end
        end

        WDATA: begin
          dataShift = 1'b1;
          if (dataLast) begin
            loadDataWr = 1'b1;
            stateNext  = HTAR;
            phaseNext  = 1'b0;
          end
        end

        // The bank registers its data on the clock after Rd, so the second
        // turnaround clock is the first one where DataRd can be captured.
        HTAR: begin
          if (!phase) begin
            phaseNext = 1'b1;
          end else begin
            latchRd   = !cycWrite;
            phaseNext = 1'b0;
`ifdef LPC_SHORT_WAIT_EN
            stateNext = WAIT;
`else
            stateNext = SYNC;
`endif
          end
        end

`ifdef LPC_SHORT_WAIT_EN
        WAIT: begin
          stateNext = SYNC;
        end
`endif

        SYNC: begin
          stateNext = cycWrite ? PTAR : RDATA;
          phaseNext = 1'b0;
        end

        RDATA: begin
          if (!phase) begin
            phaseNext = 1'b1;
          end else begin
            stateNext = PTAR;
            phaseNext = 1'b0;
          end
        end

        PTAR: begin
          if (!phase) begin
            phaseNext = 1'b1;
          end else begin
            stateNext = IDLE;
            phaseNext = 1'b0;
          end
        end

        default: begin
          stateNext = IDLE;
          phaseNext = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge LpcClock) begin
    if (PciReset) begin
      Rd       <= 1'b0;
      Addr     <= 8'h00;
      DataWr   <= 8'h00;
      cycWrite <= 1'b0;
      rdLatch  <= 8'h00;
    end else begin
      Rd <= setRd;
      if (loadAddr) begin
        Addr <= addrNext[7:0];
      end
      if (loadDataWr) begin
        DataWr <= dataNext;
      end
      if (cycTypeLoad) begin
        cycWrite <= cycTypeWrite;
      end
      if (latchRd) begin
        rdLatch <= DataRd;
      end
    end
  end

  // LAD drive and the write strobe follow the registered state directly,
  // which makes them fall back to reset values on the clock after reset.
  always_comb begin
    LadOe  = 1'b0;
    LadOut = LAD_IDLE;
    Wr     = 1'b0;
    case (state)
`ifdef LPC_SHORT_WAIT_EN
      WAIT: begin
        LadOe  = 1'b1;
        LadOut = SYNC_SHORT_WAIT;
      end
`endif
      SYNC: begin
        LadOe  = 1'b1;
        LadOut = SYNC_READY;
        Wr     = cycWrite;
      end
      RDATA: begin
        LadOe  = 1'b1;
        LadOut = phase ? rdLatch[7:4] : rdLatch[3:0];
      end
      PTAR: begin
        LadOe  = !phase;
        LadOut = LAD_IDLE;
      end
      default: begin
        LadOe  = 1'b0;
        LadOut = LAD_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_lpc_io_target.sv
// ---------------------------------------------------------------------------
// tb_lpc_io_target
//   Directed bench for lpc_io_target: write, read, window miss, abort by a
//   new START, reset during SYNC and a write covering the short-wait timing.
//   Expected values come from the cycle tables of the LPC I/O protocol;
//   define LPC_SHORT_WAIT_EN for both bench and RTL to check that build.
// ---------------------------------------------------------------------------
module tb_lpc_io_target;

`ifdef LPC_SHORT_WAIT_EN
  localparam int W = 1;
`else
  localparam int W = 0;
`endif
  localparam int LAST_C = 12 + W;

  logic       LpcClock = 1'b0;
  logic       PciReset;
  logic       LFRAME_n;
  logic [3:0] LadIn;
  logic [3:0] LadOut;
  logic       LadOe;
  logic [7:0] Addr;
  logic       Rd;
  logic       Wr;
  logic [7:0] DataWr;
  logic [7:0] DataRd;

  logic [7:0] bankValue;
  int         checkCount = 0;
  int         passCount  = 0;

  lpc_io_target #(.BASE_ADDR(16'h0800)) dut (
    .LpcClock(LpcClock),
    .PciReset(PciReset),
    .LFRAME_n(LFRAME_n),
    .LadIn   (LadIn),
    .LadOut  (LadOut),
    .LadOe   (LadOe),
    .Addr    (Addr),
    .Rd      (Rd),
    .Wr      (Wr),
    .DataWr  (DataWr),
    .DataRd  (DataRd)
  );

  always #15 LpcClock = ~LpcClock;

  // Register bank stand-in: returns bankValue one clock after Rd.
  always @(posedge LpcClock) begin
    if (PciReset) begin
      DataRd <= 8'h00;
    end else if (Rd) begin
      DataRd <= bankValue;
    end
  end

  task automatic checkOutput(input string tag, input logic [15:0] actual,
                             input logic [15:0] expected);
    checkCount++;
    if (actual === expected) begin
      passCount++;
    end else begin
      $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
    end
  endtask

  // One LPC clock: inputs change just after the rising edge, outputs for
  // that same clock are then observed at the falling edge.
  task automatic applyStimulus(input logic frame, input logic [3:0] lad,
                               input logic rst);
    @(posedge LpcClock);
    #1;
    LFRAME_n = frame;
    LadIn    = lad;
    PciReset = rst;
    @(negedge LpcClock);
  endtask

  function automatic logic [4:0] hostNibble(input int c, input bit isWrite,
                                            input logic [15:0] addr,
                                            input logic [7:0] data);
    logic [15:0] sh;
    if (c == 0) return {1'b0, 4'h0};
    if (c == 1) return {1'b1, (isWrite ? 4'h2 : 4'h0)};
    if (c >= 2 && c <= 5) begin
      sh = addr >> (4 * (5 - c));
      return {1'b1, sh[3:0]};
    end
    if (isWrite && c == 6) return {1'b1, data[3:0]};
    if (isWrite && c == 7) return {1'b1, data[7:4]};
    return {1'b1, 4'hF};
  endfunction

  function automatic logic expOe(input int c, input bit isWrite, input bit hit);
    int s;
    int len;
    s   = isWrite ? 10 : 8;
    len = isWrite ? 1 : 3;
    return hit && (c >= s) && (c <= s + len + W);
  endfunction

  function automatic logic [3:0] expLad(input int c, input bit isWrite,
                                        input bit hit, input logic [7:0] data);
    int s;
    int r;
    s = isWrite ? 10 : 8;
    if (!hit) return 4'hF;
    if (W == 1 && c == s) return 4'h5;
    r = c - s - W;
    if (r == 0) return 4'h0;
    if (!isWrite && r == 1) return data[3:0];
    if (!isWrite && r == 2) return data[7:4];
    return 4'hF;
  endfunction

  task automatic runCycle(input bit isWrite, input logic [15:0] addr,
                          input logic [7:0] data, input bit hit,
                          input int fromC, input int toC, input string name);
    logic [4:0] hn;
    for (int c = fromC; c <= toC; c++) begin
      hn = hostNibble(c, isWrite, addr, data);
      applyStimulus(hn[4], hn[3:0], 1'b0);
      checkOutput($sformatf("%s c%0d LadOe", name, c), 16'(LadOe),
                  16'(expOe(c, isWrite, hit)));
      checkOutput($sformatf("%s c%0d LadOut", name, c), 16'(LadOut),
                  16'(expLad(c, isWrite, hit, data)));
      checkOutput($sformatf("%s c%0d Rd", name, c), 16'(Rd),
                  16'(hit && !isWrite && c == 6));
      checkOutput($sformatf("%s c%0d Wr", name, c), 16'(Wr),
                  16'(hit && isWrite && c == 10 + W));
      if (hit && !isWrite && c == 6) begin
        checkOutput($sformatf("%s Addr", name), 16'(Addr), 16'(addr[7:0]));
      end
      if (hit && isWrite && c == 10 + W) begin
        checkOutput($sformatf("%s Addr", name), 16'(Addr), 16'(addr[7:0]));
        checkOutput($sformatf("%s DataWr", name), 16'(DataWr), 16'(data));
      end
    end
  endtask

  task automatic idleClocks(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b1, 4'hF, 1'b0);
      checkOutput("idle LadOe", 16'(LadOe), 16'h0);
    end
  endtask

  task automatic checkResetValues(input string name);
    checkOutput($sformatf("%s LadOe", name), 16'(LadOe), 16'h0);
    checkOutput($sformatf("%s LadOut", name), 16'(LadOut), 16'hF);
    checkOutput($sformatf("%s Rd", name), 16'(Rd), 16'h0);
    checkOutput($sformatf("%s Wr", name), 16'(Wr), 16'h0);
    checkOutput($sformatf("%s Addr", name), 16'(Addr), 16'h00);
  endtask

  initial begin
    LFRAME_n  = 1'b1;
    LadIn     = 4'hF;
    PciReset  = 1'b1;
    bankValue = 8'h00;

    applyStimulus(1'b1, 4'hF, 1'b1);
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkResetValues("reset");
    checkOutput("reset DataWr", 16'(DataWr), 16'h00);
    idleClocks(2);

    // I/O write 0x0805 <- 0x3C
    runCycle(1'b1, 16'h0805, 8'h3C, 1'b1, 0, LAST_C, "wr0805");
    idleClocks(2);

    // I/O read 0x0801, bank returns 0x55
    bankValue = 8'h55;
    runCycle(1'b0, 16'h0801, 8'h55, 1'b1, 0, LAST_C, "rd0801");
    idleClocks(2);

    // Read outside the window: bus stays quiet, Addr keeps its old value
    bankValue = 8'hEE;
    runCycle(1'b0, 16'h0900, 8'hEE, 1'b0, 0, LAST_C, "rd0900miss");
    checkOutput("miss Addr held", 16'(Addr), 16'h01);
    idleClocks(2);

    // Write 0x0820 aborted by a START at c7, that START begins a read
    runCycle(1'b1, 16'h0820, 8'h77, 1'b1, 0, 6, "abortWr");
    bankValue = 8'hA6;
    runCycle(1'b0, 16'h0802, 8'hA6, 1'b1, 0, LAST_C, "abortRd");
    checkOutput("abort DataWr held", 16'(DataWr), 16'h3C);
    checkOutput("abort Addr", 16'(Addr), 16'h02);
    idleClocks(2);

    // Reset asserted during the first SYNC-phase clock of a read
    bankValue = 8'h33;
    runCycle(1'b0, 16'h0801, 8'h33, 1'b1, 0, 7, "rstRd");
    applyStimulus(1'b1, 4'hF, 1'b1);
    checkOutput("rstRd c8 LadOe", 16'(LadOe), 16'(expOe(8, 1'b0, 1'b1)));
    checkOutput("rstRd c8 LadOut", 16'(LadOut), 16'(expLad(8, 1'b0, 1'b1, 8'h33)));
    applyStimulus(1'b1, 4'hF, 1'b0);
    checkResetValues("afterRst");
    checkOutput("afterRst DataWr", 16'(DataWr), 16'h00);
    idleClocks(2);
    bankValue = 8'h9E;
    runCycle(1'b0, 16'h08FF, 8'h9E, 1'b1, 0, LAST_C, "rd08FF");
    idleClocks(2);

    // Write 0x0810 <- 0xA5 (short-wait timing when that build is selected)
    runCycle(1'b1, 16'h0810, 8'hA5, 1'b1, 0, LAST_C, "wr0810");
    idleClocks(2);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
